// File: rtl/ihex_loader.sv
// ihex_loader: Intel HEX record parser feeding a small address/data write FIFO.
// Optional: define IHEX_LINEAR_ADDR_EN to honour type 04 (extended linear address) records.
module ihex_loader #(
    parameter int ADDR_W     = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              ce_i,
    input  logic [7:0]        data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, COUNT, ADDR, TYPE, DATA, CHECK, ERROR} state_t;

    state_t              state_q;
    logic [1:0]          nib_q;
    logic [11:0]         sh_q;
    logic [7:0]          csum_q;
    logic [7:0]          len_q;
    logic [7:0]          rem_q;
    logic [7:0]          type_q;
    logic [15:0]         off_q;
    logic [15:0]         pay_q;
    logic [ADDR_W-1:0]   base_q;
    logic                done_q;
    logic                err_q;
    logic [1:0]          code_q;
    logic [ADDR_W+7:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wp_q;
    logic [PW-1:0]       rp_q;
    logic [PW:0]         cnt_q;
    logic                acc;
    logic                hex;
    logic                full;
    logic                push;
    logic                pop;
    logic [3:0]          nib;
    logic [7:0]          byte_v;
    logic [15:0]         word;
    logic [7:0]          sum;
    logic [ADDR_W-1:0]   waddr;
    logic [ADDR_W+7:0]   head;

    // Character decode, handshakes and the write-side address of the byte being completed
    always_comb begin
        hex        = data_i inside {[8'h30:8'h39], [8'h41:8'h46], [8'h61:8'h66]};
        nib        = data_i[6] ? data_i[3:0] + 4'd9 : data_i[3:0];
        byte_v     = {sh_q[3:0], nib};
        word       = {sh_q, nib};
        sum        = csum_q + byte_v;
        full       = cnt_q == (PW+1)'(FIFO_DEPTH);
        rx_ready_o = !full;
        acc        = ce_i && rx_valid_i && rx_ready_o;
        push       = acc && hex && state_q == DATA && nib_q[0] && type_q == 8'h00;
        wr_valid_o = cnt_q != '0;
        pop        = ce_i && wr_valid_o && wr_ready_i;
        waddr      = base_q + ADDR_W'(off_q);
        head       = mem_q[rp_q];
        wr_addr_o  = wr_valid_o ? head[ADDR_W+7:8] : '0;
        wr_data_o  = wr_valid_o ? head[7:0] : '0;
        done_o     = done_q;
        error_o    = err_q;
        err_code_o = code_q;
    end

    // Record parser: one hex digit per accepted character, bytes assembled MSB nibble first
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nib_q   <= '0;
            sh_q    <= '0;
            csum_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            type_q  <= '0;
            off_q   <= '0;
            pay_q   <= '0;
            base_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else if (ce_i) begin
            if (acc && (state_q == IDLE || state_q == ERROR)) begin
                if (data_i == 8'h3A) begin
                    state_q <= COUNT;
                    nib_q   <= '0;
                    csum_q  <= '0;
                    pay_q   <= '0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    code_q  <= 2'b00;
                end else begin
                    state_q <= IDLE;
                end
            end else if (state_q == ERROR) begin
                state_q <= IDLE;
            end else if (acc && !hex) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
                code_q  <= 2'b01;
            end else if (acc) begin
                nib_q <= nib_q + 2'd1;
                sh_q  <= word[11:0];
                if (nib_q[0]) csum_q <= sum;
                case (state_q)
                    COUNT: if (nib_q[0]) begin
                        len_q   <= byte_v;
                        state_q <= ADDR;
                        nib_q   <= '0;
                    end
                    ADDR: if (nib_q == 2'd3) begin
                        off_q   <= word;
                        state_q <= TYPE;
                        nib_q   <= '0;
                    end
                    TYPE: if (nib_q[0]) begin
                        type_q  <= byte_v;
                        rem_q   <= len_q;
                        state_q <= (len_q == 8'd0) ? CHECK : DATA;
                        nib_q   <= '0;
                    end
                    DATA: if (nib_q[0]) begin
                        rem_q <= rem_q - 8'd1;
                        pay_q <= {pay_q[7:0], byte_v};
                        off_q <= off_q + 16'd1;
                        if (type_q == 8'h00 && full) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                            code_q  <= 2'b11;
                        end else if (rem_q == 8'd1) begin
                            state_q <= CHECK;
                            nib_q   <= '0;
                        end
                    end
                    CHECK: if (nib_q[0]) begin
                        if (sum != 8'd0) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                            code_q  <= 2'b10;
                        end else begin
                            state_q <= IDLE;
                            done_q  <= done_q | (type_q == 8'h01);
                            if (type_q == 8'h02) base_q <= ADDR_W'({pay_q, 4'h0});
`ifdef IHEX_LINEAR_ADDR_EN
                            if (type_q == 8'h04) base_q <= ADDR_W'({pay_q, 16'h0});
`else
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // FIFO storage is not reset; the head is masked while the FIFO is empty
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q] <= {waddr, byte_v};
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (ce_i) begin
            if (push) wp_q <= wp_q + 1'b1;
            if (pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule
